// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encodings and digit helpers for the serial BCD adder/subtractor.
package bcd_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  // Nine's complement of one BCD digit; undefined for non-BCD input.
  function automatic logic [3:0] nines_comp(input logic [3:0] dig);
    return BCD_MAX - dig;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with carry in/out; shared by every digit position of the serial unit.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] d,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (t > 5'd9) begin
      d  = t[3:0] + BCD_ADJ;
      co = 1'b1;
    end else begin
      d  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock LSD first, start/done handshake.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned CW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              neg,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [4*NDIG-1:0] a_q, a_d;
  logic [4*NDIG-1:0] b_q, b_d;
  logic [4*NDIG-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0] a_dig, b_dig, y_dig, res_dig;
  logic       res_co;

  // Operands are shifted right each RUN cycle so the current digit is always at [3:0].
  assign a_dig = a_q[3:0];
  assign b_dig = b_q[3:0];
  assign y_dig = sub_q ? nines_comp(b_dig) : b_dig;

  bcd_digit_add u_digit_add (
    .x   (a_dig),
    .y   (y_dig),
    .cin (carry_q),
    .d   (res_dig),
    .co  (res_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    done_d  = 1'b0;
    // Status outputs are registered, so busy/done trail the state by one cycle.
    busy_d  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          err_d   = 1'b0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NDIG); i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = res_dig;
        end
        carry_d = res_co;
        err_d   = err_q | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cout_d  = carry_q;
        neg_d   = sub_q & ~carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: vector table, random decimal model, handshake corners.
module tb_bcd_serial_addsub;

  localparam int NDIG = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        neg;
    logic        err;
    logic        chk_sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, neg, err;
  logic [15:0] sum;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1, done1, cout1, neg1, err1;
  logic [3:0]  sum1;

  int n_vec = 0;
  int n_miss = 0;
  vec_t sbq[$];
  vec_t mon_e;
  vec_t vecs[12];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.NDIG(NDIG), .CW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .neg(neg), .err(err)
  );

  bcd_serial_addsub #(.NDIG(1), .CW(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(1'b0), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .neg(neg1), .err(err1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                              input logic [15:0] vsum, input logic vc, input logic vn,
                              input logic ve, input logic vchk);
    vec_t r;
    r.a = va; r.b = vb; r.sub = vs; r.sum = vsum;
    r.cout = vc; r.neg = vn; r.err = ve; r.chk_sum = vchk;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: subtract is a + (9999 - b) + 1 taken modulo 10^4.
  function automatic vec_t model(input logic [15:0] va, input logic [15:0] vb, input logic vs);
    int r;
    if (vs) r = bcd2int(va) + (9999 - bcd2int(vb)) + 1;
    else    r = bcd2int(va) + bcd2int(vb);
    return mk(va, vb, vs, int2bcd(r % 10000), r >= 10000, vs && (r < 10000), 1'b0, 1'b1);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 required no pending operation");
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk_sum) begin
          check("sum", 32'(sum), 32'(mon_e.sum));
          check("cout", 32'(cout), 32'(mon_e.cout));
          check("neg", 32'(neg), 32'(mon_e.neg));
        end
        check("err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic run_op(input vec_t v, output int lat, output int nbusy);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    sbq.push_back(v);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = int'(busy);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy);
    end
    if (lat >= 40) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done in %0d cycles required done", lat);
    end
  endtask

  initial begin
    int lat, nbusy, ndone;
    vec_t v;

    vecs[0]  = mk(16'h0007, 16'h0009, 1'b0, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(16'h0053, 16'h0017, 1'b1, 16'h0036, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(16'h0017, 16'h0053, 1'b1, 16'h9964, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(16'h00A3, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(16'h5678, 16'h4322, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(16'h1000, 16'h0001, 1'b1, 16'h0999, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk(16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(16'h0005, 16'h0F00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_neg", 32'(neg), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    // Single-digit build: 7 + 9.
    @(negedge clk);
    a1 = 4'h7; b1 = 4'h9; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    while (done1 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ndig1_latency", 32'(lat), 3);
    check("ndig1_sum", 32'(sum1), 32'h6);
    check("ndig1_cout", 32'(cout1), 1);
    check("ndig1_neg", 32'(neg1), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i], lat, nbusy);
      check("latency", 32'(lat), NDIG + 2);
      check("busy_cycles", 32'(nbusy), NDIG + 1);
    end

    for (int i = 0; i < 8; i++) begin
      v = model(int2bcd(int'($urandom_range(9999))), int2bcd(int'($urandom_range(9999))),
                1'($urandom_range(1)));
      run_op(v, lat, nbusy);
      check("rand_latency", 32'(lat), NDIG + 2);
    end

    // A second start two cycles after an accepted one must be dropped.
    @(negedge clk);
    a = 16'h2222; b = 16'h3333; sub = 1'b0; start = 1'b1;
    sbq.push_back(mk(16'h2222, 16'h3333, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("ignored_start_done_count", 32'(ndone), 1);

    // Abort in the RUN cycle that processes digit 2.
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; sub = 1'b0; start = 1'b1;
    sbq.push_back(mk(16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 1);
    check("pre_abort_sum", 32'(sum), 32'h0022);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(sum), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("abort_no_done", 32'(ndone), 0);

    run_op(mk(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1), lat, nbusy);
    check("post_abort_latency", 32'(lat), NDIG + 2);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
